// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter and its requester clients: state
// encodings, bus widths, default job sizing and a grant-select helper.
package arb_pkg;

  localparam int unsigned GNT_W = 4;
  localparam int unsigned PEND_W = 3;

  // Requester FSM encodings (2-bit, kept compatible with the arbiter side)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_OWN     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Default job sizing
  localparam int unsigned BURST_LEN_DEF = 4;
  localparam int unsigned WAIT_MAX_DEF  = 15;
  localparam int unsigned MAX_PEND_DEF  = 7;

  // Pick this client's bit out of the one-hot grant bus
  function automatic logic own_grant(input logic [GNT_W-1:0] gnt, input logic [1:0] id);
    return gnt[id];
  endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Job/arbiter handshake bundle for one requester client.
interface arb_requester_if;
  import arb_pkg::*;

  logic              job_valid;
  logic              job_ready;
  logic [GNT_W-1:0]  gnt;
  logic              req;
  logic              beat;
  logic              done;
  logic              timeout;
  logic [PEND_W-1:0] pend_cnt;

  // Requester side
  modport master (
    input  job_valid, gnt,
    output job_ready, req, beat, done, timeout, pend_cnt
  );

  // Job source / arbiter side
  modport slave (
    output job_valid, gnt,
    input  job_ready, req, beat, done, timeout, pend_cnt
  );
endinterface

// File: rtl/arb_req_cnt.sv
// Loadable up-counter with a terminal-count flag; load wins over increment.
module arb_req_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TERM  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_r;

  // Count register: load, increment or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (inc) begin
      cnt_r <= cnt_r + ONE_V;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == TERM_V);

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: queues jobs, requests the bus, consumes BURST_LEN granted
// beats per job and gives up after WAIT_MAX ungranted cycles (job retried).
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned REQ_ID    = 0,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned WAIT_MAX  = WAIT_MAX_DEF,
  parameter int unsigned MAX_PEND  = MAX_PEND_DEF
) (
  input logic              clk,
  input logic              rst,
  arb_requester_if.master  bus
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [PEND_W-1:0] pend_r;
  logic              gnt_own_s;
  logic              accept_s;
  logic              wait_inc_s;
  logic              wait_clr_s;
  logic              wait_tc_s;
  logic              beat_inc_s;
  logic              beat_clr_s;
  logic              beat_tc_s;
  logic              beat_s;
  logic              done_s;
  logic              timeout_s;

  assign gnt_own_s = own_grant(bus.gnt, 2'(REQ_ID));
  assign accept_s  = bus.job_valid && bus.job_ready;

  // Outputs decoded from registered state; grant only matters in REQUEST/OWN
  assign beat_s    = (state_r == ST_OWN) && gnt_own_s;
  assign done_s    = beat_s && beat_tc_s;
  assign timeout_s = (state_r == ST_REQUEST) && !gnt_own_s && wait_tc_s;

  assign bus.req       = (state_r == ST_REQUEST) || (state_r == ST_OWN);
  assign bus.beat      = beat_s;
  assign bus.done      = done_s;
  assign bus.timeout   = timeout_s;
  assign bus.job_ready = (pend_r < PEND_W'(MAX_PEND));
  assign bus.pend_cnt  = pend_r;

  // Next-state and counter control
  always_comb begin
    state_nxt_s = state_r;
    wait_inc_s  = 1'b0;
    wait_clr_s  = 1'b0;
    beat_inc_s  = 1'b0;
    beat_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_r != '0) begin
          state_nxt_s = ST_REQUEST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (gnt_own_s) begin
          state_nxt_s = ST_OWN;
          wait_clr_s  = 1'b1;
        end else if (wait_tc_s) begin
          state_nxt_s = ST_RELEASE;
          wait_clr_s  = 1'b1;
        end else begin
          wait_inc_s  = 1'b1;
        end
      end
      ST_OWN: begin
        if (gnt_own_s) begin
          beat_inc_s = 1'b1;
          if (beat_tc_s) begin
            beat_clr_s  = 1'b1;
            state_nxt_s = ST_RELEASE;
          end else begin
            state_nxt_s = ST_OWN;
          end
        end else begin
          // Grant lost: re-request, partial beat count is kept
          state_nxt_s = ST_REQUEST;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending-job count: +1 on accept, -1 on done, unchanged when both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
    end else if (accept_s && !done_s) begin
      pend_r <= pend_r + PEND_W'(1);
    end else if (!accept_s && done_s) begin
      pend_r <= pend_r - PEND_W'(1);
    end else begin
      pend_r <= pend_r;
    end
  end

  arb_req_cnt #(.WIDTH(8), .TERM(WAIT_MAX - 1)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_clr_s),
    .load_val (8'd0),
    .inc      (wait_inc_s),
    .tc       (wait_tc_s)
  );

  arb_req_cnt #(.WIDTH(4), .TERM(BURST_LEN - 1)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_clr_s),
    .load_val (4'd0),
    .inc      (beat_inc_s),
    .tc       (beat_tc_s)
  );

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester (REQ_ID=2, BURST_LEN=4, WAIT_MAX=15, MAX_PEND=7).
// Per-cycle expectations are queued as stimulus is driven and compared
// against the outputs sampled on the following falling edge.
module tb_arb_requester;

  localparam logic [3:0] G = 4'b0100;  // own grant
  localparam logic [3:0] N = 4'b0000;  // no grant
  localparam logic [3:0] X = 4'b1011;  // grants to other clients only

  typedef struct {
    logic       rst;
    logic       jv;
    logic [3:0] gnt;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  vec_t vecs[$];
  logic [7:0] exp_q[$];

  arb_requester_if bus();

  arb_requester #(
    .REQ_ID(2), .BURST_LEN(4), .WAIT_MAX(15), .MAX_PEND(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req, beat, done, timeout, job_ready, pend_cnt}
  function automatic logic [7:0] ex(input logic r, input logic b, input logic d,
                                    input logic t, input logic y, input logic [2:0] p);
    return {r, b, d, t, y, p};
  endfunction

  task automatic add(input logic r, input logic jv, input logic [3:0] g, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.jv = jv; v.gnt = g; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge
  task automatic apply(input logic r, input logic jv, input logic [3:0] g,
                       input logic [7:0] e, input string name);
    logic [7:0] act;
    logic [7:0] want;
    @(posedge clk);
    #1;
    rst = r;
    bus.job_valid = jv;
    bus.gnt = g;
    exp_q.push_back(e);
    @(negedge clk);
    act = {bus.req, bus.beat, bus.done, bus.timeout, bus.job_ready, bus.pend_cnt};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s scoreboard empty, act=%b", name, act);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        n_miss++;
        $display("FAIL %s act={req,beat,done,tmo,rdy,pend}=%b exp=%b", name, act, want);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.gnt = N;

    // Reset, then one job with grant held high
    add(1, 0, N, ex(0,0,0,0,1,0));
    add(0, 1, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,1));
    add(0, 0, G, ex(1,0,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,1,0,1,1));
    add(0, 0, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,0));
    // Grant lost after beat 2 for 3 cycles, then restored
    add(0, 1, N, ex(0,0,0,0,1,0));
    add(0, 0, N, ex(0,0,0,0,1,1));
    add(0, 0, G, ex(1,0,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, N, ex(1,0,0,0,1,1));
    add(0, 0, N, ex(1,0,0,0,1,1));
    add(0, 0, X, ex(1,0,0,0,1,1));
    add(0, 0, G, ex(1,0,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,1,0,1,1));
    add(0, 0, N, ex(0,0,0,0,1,0));
    add(0, 0, N, ex(0,0,0,0,1,0));
    // Three queued, accept coincides with done at pend_cnt=3
    add(0, 1, N, ex(0,0,0,0,1,0));
    add(0, 1, N, ex(0,0,0,0,1,1));
    add(0, 1, N, ex(1,0,0,0,1,2));
    add(0, 0, G, ex(1,0,0,0,1,3));
    add(0, 0, G, ex(1,1,0,0,1,3));
    add(0, 0, G, ex(1,1,0,0,1,3));
    add(0, 0, G, ex(1,1,0,0,1,3));
    add(0, 1, G, ex(1,1,1,0,1,3));
    add(0, 0, G, ex(0,0,0,0,1,3));
    add(0, 0, G, ex(0,0,0,0,1,3));
    add(0, 0, G, ex(1,0,0,0,1,3));
    add(0, 0, G, ex(1,1,0,0,1,3));
    // Reset during beat 2: everything cleared, fresh job runs a full burst
    add(1, 0, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,0));
    add(0, 1, G, ex(0,0,0,0,1,0));
    add(0, 0, G, ex(0,0,0,0,1,1));
    add(0, 0, G, ex(1,0,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,0,0,1,1));
    add(0, 0, G, ex(1,1,1,0,1,1));
    add(0, 0, N, ex(0,0,0,0,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].jv, vecs[i].gnt, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Never granted: timeout in the 15th REQUEST cycle, release, idle, retry
    apply(0, 1, N, ex(0,0,0,0,1,0), "tmo_accept");
    apply(0, 0, N, ex(0,0,0,0,1,1), "tmo_idle");
    for (int k = 0; k < 15; k++) begin
      apply(0, 0, X, ex(1'b1, 1'b0, 1'b0, (k == 14), 1'b1, 3'd1), $sformatf("tmo_wait%0d", k));
    end
    apply(0, 0, X, ex(0,0,0,0,1,1), "tmo_release");
    apply(0, 0, X, ex(0,0,0,0,1,1), "tmo_reidle");
    apply(0, 0, X, ex(1,0,0,0,1,1), "tmo_rereq");

    // job_valid held 10 cycles without grant: pend_cnt saturates at 7
    for (int k = 0; k < 10; k++) begin
      logic [2:0] p;
      p = (k < 6) ? 3'(k + 1) : 3'd7;
      apply(0, 1, N, ex(1'b1, 1'b0, 1'b0, 1'b0, (p != 3'd7), p), $sformatf("sat%0d", k));
    end
    apply(0, 0, N, ex(1,0,0,0,0,7), "sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter REQ_ID, default 0, meaning the arbiter port index (0..3) this client owns.
REQ-002 Parameter BURST_LEN, default 4, meaning granted beats per job (1..15).
REQ-003 Parameter WAIT_MAX, default 15, meaning cycles in REQUEST without grant before timeout (1..255).
REQ-004 Parameter MAX_PEND, default 7, meaning maximum queued jobs (1..7).
REQ-005 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  is the asynchronous, active-high reset.
REQ-007 Port job_valid  input  1  means a new job is offered.
REQ-008 Port job_ready  output  1  means a job can be accepted; it SHALL equal (pend_cnt < MAX_PEND).
REQ-009 Port gnt  input  4  is the one-hot grant bus from the round-robin arbiter.
REQ-010 Port req  output  1  is the request line to arbiter bit REQ_ID.
REQ-011 Port beat  output  1  is high in each cycle a burst beat is consumed.
REQ-012 Port done  output  1  is a one-cycle pulse when a job's final beat is consumed.
REQ-013 Port timeout  output  1  is a one-cycle pulse when a wait expires.
REQ-014 Port pend_cnt  output  3  is the number of queued jobs, including the active job.

Function
REQ-015 The FSM SHALL have states IDLE, REQUEST, OWN and RELEASE.
REQ-016 IDLE: req=0; the FSM SHALL go to REQUEST on the next edge when pend_cnt>0.
REQ-017 REQUEST: req=1; wait_cnt SHALL increment each cycle that gnt[REQ_ID]=0.
- If gnt[REQ_ID]=1, go to OWN and clear wait_cnt.
- Else if wait_cnt reaches WAIT_MAX-1, pulse timeout, go to RELEASE and clear wait_cnt.
REQ-018 OWN: req=1; each cycle with gnt[REQ_ID]=1 SHALL assert beat and increment beat_cnt.
REQ-019 When the beat with beat_cnt=BURST_LEN-1 is consumed, the block SHALL pulse done in that same cycle, clear beat_cnt, decrement pend_cnt and go to RELEASE.
REQ-020 OWN with gnt[REQ_ID]=0 (grant lost) SHALL return to REQUEST with beat_cnt preserved and no beat.
REQ-021 RELEASE: req=0 for exactly one cycle, then IDLE; a timed-out job stays queued and is retried.
REQ-022 A job SHALL be accepted when job_valid and job_ready are both high; acceptance increments pend_cnt.
REQ-023 An acceptance and a done in the same cycle SHALL leave pend_cnt unchanged.
REQ-024 gnt bits other than REQ_ID SHALL be ignored; gnt[REQ_ID] SHALL be ignored in IDLE and RELEASE.
REQ-025 beat SHALL equal (state==OWN && gnt[REQ_ID]), combinational from registered state; done and timeout SHALL be registered-state-qualified combinational pulses.

Reset
REQ-026 While rst=1, state=IDLE and all counters are 0; req, beat, done and timeout are 0, job_ready=1 and pend_cnt=0.
REQ-027 Reset mid-burst SHALL discard all queued and partial jobs, with no done pulse.

Structure
REQ-028 State encodings (2-bit) and the default BURST_LEN, WAIT_MAX and MAX_PEND values SHALL live in the shared package arb_pkg, which the arbiter also uses.
REQ-029 The wait/beat counting SHALL be one sub-module, arb_req_cnt: a loadable up-counter with a terminal-count flag, instantiated twice.

Verification
REQ-030 Queue one job with gnt[REQ_ID] held high (BURST_LEN=4): req rises 1 cycle after acceptance, there are 4 beat cycles, done coincides with the 4th beat, req is low for 1 cycle, and pend_cnt ends at 0.
REQ-031 Grant is dropped after beat 2 for 3 cycles, then restored: the FSM returns to REQUEST, no beats occur during the gap, 2 more beats follow, and exactly one done is produced.
REQ-032 Grant is never given (WAIT_MAX=15): timeout pulses 15 cycles after req rises, req is low 1 cycle, req rises again, and pend_cnt stays 1.
REQ-033 job_valid is held high for 10 cycles with no grant: pend_cnt saturates at 7, job_ready=0, and no further acceptances occur.
REQ-034 Accept a job in the same cycle as done with pend_cnt=3: pend_cnt stays 3 and the next burst starts after RELEASE.
REQ-035 Assert rst for 1 cycle during beat 2: all outputs return to reset values immediately, and there is no done or req until a new job is accepted.
